// File: rtl/result_quant_packer.sv
// Requantizes Winograd PE results to DATA_BIT and serializes tiles (1 pooled / 4 unpooled beats)
// through a 2-entry tile buffer with valid/ready output and a sticky drop flag.
module result_quant_packer #(
  parameter int X_PE        = 16,
  parameter int RESULT_SIZE = 2,
  parameter int OUT_BIT     = 24,
  parameter int DATA_BIT    = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  input  logic                                          poolop,
  input  logic [OUT_BIT*RESULT_SIZE*RESULT_SIZE*X_PE-1:0] result_unpool,
  input  logic [OUT_BIT*X_PE-1:0]                       result_pool,
  input  logic [4:0]                                    shift,
  input  logic                                          relu_en,
  input  logic                                          ovf_clr,
  input  logic                                          out_ready,
  output logic                                          out_valid,
  output logic [DATA_BIT*X_PE-1:0]                      out_data,
  output logic                                          out_last,
  output logic                                          overflow
);

  localparam int PIX = RESULT_SIZE * RESULT_SIZE;
  localparam int VW  = DATA_BIT * X_PE;
  localparam int QW  = OUT_BIT + 1;
  localparam logic signed [QW-1:0] SAT_MAX   = QW'((2 ** (DATA_BIT - 1)) - 1);
  localparam logic signed [QW-1:0] SAT_MIN   = ~SAT_MAX;
  localparam logic [1:0]           LAST_BEAT = 2'(PIX - 1);

  // One extra bit of headroom keeps the rounding add from wrapping at full-scale positive input.
  function automatic logic [DATA_BIT-1:0] quantize(input logic [OUT_BIT-1:0] raw,
                                                   input logic [4:0] sh,
                                                   input logic relu);
    logic signed [QW-1:0] ext;
    logic signed [QW-1:0] rnd;
    logic signed [QW-1:0] shr;
    logic [DATA_BIT-1:0]  q;
    ext = $signed({raw[OUT_BIT-1], raw});
    if (sh == 5'd0) begin
      rnd = '0;
    end else begin
      rnd = $signed(QW'(1'b1) << (sh - 5'd1));
    end
    shr = (ext + rnd) >>> sh;
    if (relu && shr[QW-1]) begin
      shr = '0;
    end else begin
      shr = shr;
    end
    if (shr > SAT_MAX) begin
      q = SAT_MAX[DATA_BIT-1:0];
    end else if (shr < SAT_MIN) begin
      q = SAT_MIN[DATA_BIT-1:0];
    end else begin
      q = shr[DATA_BIT-1:0];
    end
    return q;
  endfunction

  logic [PIX-1:0][VW-1:0]      q_unpool_s;
  logic [VW-1:0]               q_pool_s;
  logic [PIX-1:0][VW-1:0]      q_tile_s;

  logic [1:0][PIX-1:0][VW-1:0] mem_r;
  logic [1:0]                  mode_r;
  logic                        wr_ptr_r;
  logic                        rd_ptr_r;
  logic [1:0]                  count_r;
  logic [1:0]                  beat_r;
  logic                        out_valid_r;
  logic [VW-1:0]               out_data_r;
  logic                        out_last_r;
  logic                        overflow_r;

  logic                        xfer_s;
  logic                        pop_s;
  logic                        accept_s;
  logic                        drop_s;
  logic                        wr_ptr_nxt_s;
  logic                        rd_ptr_nxt_s;
  logic [1:0]                  count_nxt_s;
  logic [1:0]                  beat_nxt_s;
  logic                        overflow_nxt_s;
  logic [VW-1:0]               data_nxt_s;
  logic                        last_nxt_s;

  // Quantize the incoming tile; a pooled tile replicates its single vector into every beat slot.
  always_comb begin
    q_unpool_s = '0;
    q_pool_s   = '0;
    q_tile_s   = '0;
    for (int k = 0; k < X_PE; k++) begin
      q_pool_s[k*DATA_BIT +: DATA_BIT] = quantize(result_pool[k*OUT_BIT +: OUT_BIT], shift, relu_en);
      for (int p = 0; p < PIX; p++) begin
        q_unpool_s[p][k*DATA_BIT +: DATA_BIT] =
          quantize(result_unpool[(k*PIX+p)*OUT_BIT +: OUT_BIT], shift, relu_en);
      end
    end
    for (int p = 0; p < PIX; p++) begin
      if (poolop) begin
        q_tile_s[p] = q_pool_s;
      end else begin
        q_tile_s[p] = q_unpool_s[p];
      end
    end
  end

  // Buffer bookkeeping: accept, final-beat pop, pointer/count/beat updates and the sticky drop flag.
  always_comb begin
    xfer_s       = out_valid_r & out_ready;
    pop_s        = xfer_s & out_last_r;
    accept_s     = in_valid & ((count_r != 2'd2) | pop_s);
    drop_s       = in_valid & ~accept_s;
    wr_ptr_nxt_s = wr_ptr_r ^ accept_s;
    rd_ptr_nxt_s = rd_ptr_r ^ pop_s;
    case ({accept_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) begin
      beat_nxt_s = 2'd0;
    end else if (xfer_s) begin
      beat_nxt_s = beat_r + 2'd1;
    end else begin
      beat_nxt_s = beat_r;
    end
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
    end else if (ovf_clr) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
  end

  // Next presented beat; the head may be the entry being written this very cycle.
  always_comb begin
    if (count_nxt_s == 2'd0) begin
      data_nxt_s = '0;
      last_nxt_s = 1'b0;
    end else if (accept_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      data_nxt_s = q_tile_s[0];
      last_nxt_s = poolop;
    end else begin
      data_nxt_s = mem_r[rd_ptr_nxt_s][beat_nxt_s];
      last_nxt_s = mode_r[rd_ptr_nxt_s] | (beat_nxt_s == LAST_BEAT);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r       <= '0;
      mode_r      <= 2'b00;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
      beat_r      <= 2'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        mem_r[wr_ptr_r]  <= q_tile_s;
        mode_r[wr_ptr_r] <= poolop;
      end else begin
        mem_r  <= mem_r;
        mode_r <= mode_r;
      end
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      beat_r      <= beat_nxt_s;
      out_valid_r <= (count_nxt_s != 2'd0);
      out_data_r  <= data_nxt_s;
      out_last_r  <= last_nxt_s;
      overflow_r  <= overflow_nxt_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_result_quant_packer.sv
// Self-checking bench for result_quant_packer: directed scenarios plus random traffic,
// compared cycle by cycle against a tile-queue reference model.
module tb_result_quant_packer;

  localparam int X_PE     = 16;
  localparam int RS       = 2;
  localparam int OUT_BIT  = 24;
  localparam int DATA_BIT = 8;
  localparam int DW       = DATA_BIT * X_PE;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        in_valid = 1'b0;
  logic                        poolop = 1'b0;
  logic [OUT_BIT*4*X_PE-1:0]   result_unpool = '0;
  logic [OUT_BIT*X_PE-1:0]     result_pool = '0;
  logic [4:0]                  shift = 5'd0;
  logic                        relu_en = 1'b0;
  logic                        ovf_clr = 1'b0;
  logic                        out_ready = 1'b0;
  logic                        out_valid;
  logic [DW-1:0]               out_data;
  logic                        out_last;
  logic                        overflow;

  result_quant_packer #(.X_PE(X_PE), .RESULT_SIZE(RS), .OUT_BIT(OUT_BIT), .DATA_BIT(DATA_BIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .poolop(poolop),
    .result_unpool(result_unpool), .result_pool(result_pool), .shift(shift),
    .relu_en(relu_en), .ovf_clr(ovf_clr), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   n;
    logic [3:0][DW-1:0]   b;
  } tile_t;

  tile_t q[$];
  int    hidx = 0;
  bit    movf = 1'b0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_BIT-1:0] ref_q(input logic [OUT_BIT-1:0] raw, input int sh, input bit relu);
    longint x;
    longint maxq;
    maxq = (longint'(1) <<< (DATA_BIT - 1)) - 1;
    x = longint'($signed(raw));
    if (sh > 0) x = x + (longint'(1) <<< (sh - 1));
    x = x >>> sh;
    if (relu && x < 0) x = 0;
    if (x > maxq) x = maxq;
    if (x < -maxq - 1) x = -maxq - 1;
    return DATA_BIT'(x);
  endfunction

  function automatic logic [OUT_BIT-1:0] rv();
    int s;
    case ($urandom_range(0, 4))
      0:       return {1'b0, {(OUT_BIT-1){1'b1}}};
      1:       return {1'b1, {(OUT_BIT-1){1'b0}}};
      2: begin
        s = int'($urandom_range(0, 2047)) - 1024;
        return OUT_BIT'(s);
      end
      default: return OUT_BIT'($urandom);
    endcase
  endfunction

  task automatic rand_data();
    for (int i = 0; i < 4 * X_PE; i++) result_unpool[i*OUT_BIT +: OUT_BIT] = rv();
    for (int i = 0; i < X_PE; i++) result_pool[i*OUT_BIT +: OUT_BIT] = rv();
  endtask

  function automatic tile_t build_tile();
    tile_t t;
    t.n = poolop ? 1 : 4;
    t.b = '0;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < X_PE; k++)
        t.b[p][k*DATA_BIT +: DATA_BIT] = poolop
          ? ref_q(result_pool[k*OUT_BIT +: OUT_BIT], int'(shift), relu_en)
          : ref_q(result_unpool[(k*4+p)*OUT_BIT +: OUT_BIT], int'(shift), relu_en);
    return t;
  endfunction

  // One clock: compare outputs with the model, advance the model with the current inputs, clock.
  task automatic step();
    bit    xfer;
    bit    fin;
    bit    acc;
    tile_t t;
    chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].b[hidx]);
      chk("out_last", DW'(out_last), DW'(hidx == q[0].n - 1));
    end
    chk("overflow", DW'(overflow), DW'(movf));
    xfer = (q.size() > 0) && out_ready;
    fin  = 1'b0;
    if (xfer) fin = (hidx == q[0].n - 1);
    acc = in_valid && (q.size() < 2 || fin);
    t = build_tile();
    if (xfer) begin
      if (fin) begin
        void'(q.pop_front());
        hidx = 0;
      end else begin
        hidx++;
      end
    end
    if (acc) q.push_back(t);
    if (in_valid && !acc) movf = 1'b1;
    else if (ovf_clr) movf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    hidx = 0;
    movf = 1'b0;
  endtask

  initial begin
    logic [5:0] lastvec;
    int         nb;

    // Reset state
    #12;
    chk("rst_valid", DW'(out_valid), DW'(1'b0));
    chk("rst_data", out_data, '0);
    chk("rst_last", DW'(out_last), DW'(1'b0));
    chk("rst_ovf", DW'(overflow), DW'(1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Requantization corner values on a pooled tile
    out_ready = 1'b1; shift = 5'd4; relu_en = 1'b0; poolop = 1'b1;
    result_pool = '0;
    result_pool[0*OUT_BIT +: OUT_BIT] = 24'd24;
    result_pool[1*OUT_BIT +: OUT_BIT] = -24'sd24;
    result_pool[2*OUT_BIT +: OUT_BIT] = 24'h7FFFFF;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("q_24", DW'(out_data[7:0]), DW'(8'd2));
    chk("q_m24", DW'(out_data[15:8]), DW'(8'hFF));
    chk("q_max", DW'(out_data[23:16]), DW'(8'd127));
    step();
    relu_en = 1'b1;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("q_relu", DW'(out_data[15:8]), DW'(8'd0));
    chk("q_relu_pos", DW'(out_data[7:0]), DW'(8'd2));
    step();
    relu_en = 1'b0;

    // Unpooled beat order
    poolop = 1'b0; shift = 5'd8;
    for (int k = 0; k < X_PE; k++)
      for (int p = 0; p < 4; p++)
        result_unpool[(k*4+p)*OUT_BIT +: OUT_BIT] = OUT_BIT'((k*4+p) << 8);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < X_PE; k++)
        chk("order", DW'(out_data[k*DATA_BIT +: DATA_BIT]), DW'(k*4+p));
      chk("order_last", DW'(out_last), DW'(p == 3));
      step();
    end
    chk("order_done", DW'(out_valid), DW'(1'b0));

    // Backpressure: two tiles held, third dropped, eight beats drain intact
    out_ready = 1'b0; shift = 5'd6;
    rand_data(); in_valid = 1'b1; step();
    rand_data(); step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rand_data(); in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("bp_ovf", DW'(overflow), DW'(1'b1));
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("bp_empty", DW'(out_valid), DW'(1'b0));
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_cleared", DW'(overflow), DW'(1'b0));

    // Boundary accept while full and the head's last beat leaves
    out_ready = 1'b0;
    rand_data(); in_valid = 1'b1; step();
    rand_data(); step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rand_data(); in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("edge_ovf", DW'(overflow), DW'(1'b0));
    chk("edge_q2", DW'(q.size()), DW'(2));
    for (int i = 0; i < 9; i++) step();

    // Mixed pooled / unpooled / pooled back to back
    nb = 0; lastvec = '0;
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 3);
      poolop = (i != 1);
      rand_data();
      if (out_valid && nb < 6) begin
        lastvec[nb] = out_last;
        nb++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("mix_beats", DW'(nb), DW'(6));
    chk("mix_last", DW'(lastvec), DW'(6'b110001));

    // Reset in the middle of an unpooled tile
    poolop = 1'b0; rand_data(); in_valid = 1'b1; step(); in_valid = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", DW'(out_valid), DW'(1'b0));
    chk("arst_data", out_data, '0);
    chk("arst_last", DW'(out_last), DW'(1'b0));
    model_reset();
    in_valid = 1'b1; poolop = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("rst_no_take", DW'(out_valid), DW'(1'b0));
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    poolop = 1'b0; rand_data(); in_valid = 1'b1; step(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 45);
      poolop    = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 99) < 70);
      shift     = 5'($urandom_range(0, 23));
      relu_en   = ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      rand_data();
      step();
    end
    in_valid = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_quant_packer.md
RESULT_QUANT_PACKER -- requirements
Module: result_quant_packer

Interface
REQ-001 SHALL take parameter X_PE, default 16: number of PE output channels per beat.
REQ-002 SHALL take parameter RESULT_SIZE, default 2: Winograd output tile edge, giving RESULT_SIZE^2 = 4 pixels per tile.
REQ-003 SHALL take parameter OUT_BIT, default 24: width of each signed PE result.
REQ-004 SHALL take parameter DATA_BIT, default 8: width of each signed quantized output.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: the PE core out_valid; there is no backpressure toward the PE.
REQ-008 SHALL have port poolop, input, 1 bit: 1 = pooled tile (1 beat), 0 = unpooled tile (4 beats); sampled with in_valid.
REQ-009 SHALL have port result_unpool, input, OUT_BIT*4*X_PE bits: channel k, pixel p at bits [(k*4+p)*OUT_BIT +: OUT_BIT], with p = row*2+col.
REQ-010 SHALL have port result_pool, input, OUT_BIT*X_PE bits: channel k at bits [k*OUT_BIT +: OUT_BIT].
REQ-011 SHALL have port shift, input, 5 bits: requantization right-shift amount, 0..23.
REQ-012 SHALL have port relu_en, input, 1 bit: clamp negative results to 0.
REQ-013 SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts a beat.
REQ-015 SHALL have port out_valid, output, 1 bit: a beat is presented.
REQ-016 SHALL have port out_data, output, DATA_BIT*X_PE bits: channel k at bits [k*DATA_BIT +: DATA_BIT].
REQ-017 SHALL have port out_last, output, 1 bit: marks the final beat of a tile.
REQ-018 SHALL have port overflow, output, 1 bit: sticky flag indicating a dropped tile.

Function
REQ-019 SHALL quantize each OUT_BIT value combinationally at capture as follows:
- add the rounding term 1<<(shift-1) when shift>0;
- arithmetic right-shift by shift;
- if relu_en, set negative values to 0;
- saturate to [-128, 127].
REQ-020 SHALL hold a 2-entry tile buffer with wr_ptr, rd_ptr, count (0..2) and beat counter beat (0..3); each entry stores 4 quantized beats plus a mode bit.
REQ-021 SHALL write the quantized tile into entry wr_ptr on a rising edge with in_valid=1, when accepted; the mode bit is the sampled poolop.
REQ-022 SHALL accept a tile when count<2, or when count==2 and the final beat of the head entry is popped in the same cycle.
REQ-023 SHALL, on a rejected tile, drop it without disturbing stored data and set overflow=1.
REQ-024 SHALL clear overflow only on ovf_clr=1 or reset; if ovf_clr and a drop occur in the same cycle, overflow=1.
REQ-025 SHALL hold out_valid=1 exactly when count>0, with 1-cycle latency: a tile captured at edge N is first visible after edge N.
REQ-026 SHALL count a beat as transferred on an edge with out_valid && out_ready; on each transfer beat increments.
REQ-027 SHALL output on out_data the pixel selected by beat for an unpooled entry, or the pooled vector for a pooled entry.
REQ-028 SHALL assert out_last when the head entry is pooled, or when it is unpooled and beat==3.
REQ-029 SHALL, on a transfer with out_last=1, reset beat to 0, advance rd_ptr (mod 2) and free the entry.
REQ-030 SHALL, on simultaneous accept and final pop, leave count unchanged and advance both pointers.
REQ-031 SHALL keep out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-032 SHALL never present partial or reordered tiles; tiles leave in arrival order.

Reset
REQ-033 SHALL, while rst_n=0 (asynchronous, any time), force the following:
- out_valid=0, out_last=0, out_data=0, overflow=0;
- count=0, beat=0, wr_ptr=0, rd_ptr=0.
REQ-034 SHALL discard buffered tiles on reset mid-tile, and require no partial-beat recovery after reset deassertion.
REQ-035 SHALL take no tile while rst_n=0, even if in_valid=1.

Verification
REQ-036 SHALL be covered by a directed scenario for requantization: shift=4, relu_en=0, pooled value 0x000018 (24) -> out 2 (24+8=32>>4); value -24 -> -1; 0x7FFFFF -> 127; relu_en=1 with -24 -> 0.
REQ-037 SHALL be covered by a directed scenario for unpooled order: one tile with pixel p of channel k = (k*4+p)<<8, shift=8, out_ready=1 -> 4 beats on consecutive cycles, beat p channel k = k*4+p, out_last only on beat 3.
REQ-038 SHALL be covered by a directed scenario for backpressure: out_ready=0 while 2 unpooled tiles arrive -> count=2, out_data stable; a third in_valid -> overflow=1 and both tiles later emerge intact (8 beats).
REQ-039 SHALL be covered by a directed scenario for the boundary accept: count=2, out_ready=1 on beat 3 of the head while in_valid=1 -> the new tile is accepted, overflow stays 0, count stays 2.
REQ-040 SHALL be covered by a directed scenario for mixed modes: pooled, unpooled, pooled back-to-back with out_ready=1 -> beats 1,4,1 with out_last on beats 1, 5 and 6 of the 6-beat stream.
REQ-041 SHALL be covered by a directed scenario for reset mid-tile: reset after beat 1 of an unpooled tile -> out_valid=0 immediately (asynchronous); after release, the next tile starts at beat 0.
